// File: rtl/ltl_mon_pkg.sv
// Shared types and symbol encoding for the LTL monitor symbol path.
package ltl_mon_pkg;

  localparam int SYM_W  = 8;
  localparam int PROP_W = 3;
  localparam int SEQ_W  = 4;

  typedef enum logic {
    ST_RESTART = 1'b0,
    ST_STREAM  = 1'b1
  } state_e;

  // The automata match on 16-aligned ranges, so seq in the low nibble is debug-only.
  function automatic logic [SYM_W-1:0] encode_symbol(input logic [PROP_W-1:0] props,
                                                     input logic [SEQ_W-1:0]  seq);
    return {1'b0, props, seq};
  endfunction

endpackage

// File: rtl/ltl_sym_fifo.sv
// Proposition-vector FIFO: async reset, sync clear, pointers with an extra wrap bit.
module ltl_sym_fifo
  import ltl_mon_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [PROP_W-1:0] din_i,
  output logic [PROP_W-1:0] dout_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wptr_q, wptr_d;
  logic [AW:0]       rptr_q, rptr_d;
  logic [PROP_W-1:0] mem_q [DEPTH];
  logic              wr_en;

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign dout_o  = mem_q[rptr_q[AW-1:0]];
  assign wr_en   = push_i && !full_o && !clr_i;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clr_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push_i && !full_o) wptr_d = wptr_q + (AW+1)'(1);
      if (pop_i && !empty_o) rptr_d = rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/ltl_symbol_streamer.sv
// Buffers proposition vectors and streams encoded symbols to the LTL automata.
// Optional LTL_SYMBOL_DEDUP_EN drops a vector equal to the last enqueued one.
module ltl_symbol_streamer
  import ltl_mon_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prop_valid,
  output logic              prop_ready,
  input  logic [PROP_W-1:0] props,
  input  logic              flush,
  input  logic              mon_stall,
  output logic [SYM_W-1:0]  symbols,
  output logic              run,
  output logic              mon_reset,
  output logic              overflow,
  output logic [CNT_W-1:0]  sym_count
);

  state_e             state_q, state_d;
  logic               rcnt_q, rcnt_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SYM_W-1:0]   sym_q, sym_d;
  logic               run_q, run_d;
  logic               ovf_q, ovf_d;

  logic               fifo_full, fifo_empty, fifo_clr;
  logic               push, pop, hs;
  logic [PROP_W-1:0]  fifo_dout;

`ifdef LTL_SYMBOL_DEDUP_EN
  logic [PROP_W-1:0]  last_q, last_d;
  logic               last_vld_q, last_vld_d;
`endif

  ltl_sym_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .clr_i   (fifo_clr),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (props),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    rcnt_d     = rcnt_q;
    seq_d      = seq_q;
    cnt_d      = cnt_q;
    sym_d      = sym_q;
    ovf_d      = ovf_q;
    run_d      = 1'b0;
    prop_ready = 1'b0;
    mon_reset  = 1'b0;
    hs         = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    fifo_clr   = 1'b0;
`ifdef LTL_SYMBOL_DEDUP_EN
    last_d     = last_q;
    last_vld_d = last_vld_q;
`endif

    case (state_q)
      ST_RESTART: begin
        mon_reset = 1'b1;
`ifdef LTL_SYMBOL_DEDUP_EN
        last_vld_d = 1'b0;
`endif
        if (rcnt_q) begin
          state_d = ST_STREAM;
          rcnt_d  = 1'b0;
        end else begin
          rcnt_d  = 1'b1;
        end
      end
      default: begin
        // A flush cycle must not handshake a vector it is about to discard.
        prop_ready = !fifo_full && !flush;
        hs         = prop_valid && prop_ready;
        pop        = !fifo_empty && !mon_stall && !flush;
        if (prop_valid && !prop_ready) ovf_d = 1'b1;
      end
    endcase

`ifdef LTL_SYMBOL_DEDUP_EN
    push = hs && !(last_vld_q && (props == last_q));
    if (hs) begin
      last_d     = props;
      last_vld_d = 1'b1;
    end
`else
    push = hs;
`endif

    if (pop) begin
      sym_d = encode_symbol(fifo_dout, seq_q);
      run_d = 1'b1;
      seq_d = seq_q + SEQ_W'(1);
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end

    if (flush) begin
      state_d  = ST_RESTART;
      rcnt_d   = 1'b0;
      fifo_clr = 1'b1;
      seq_d    = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
      run_d    = 1'b0;
`ifdef LTL_SYMBOL_DEDUP_EN
      last_vld_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RESTART;
      rcnt_q  <= 1'b0;
      seq_q   <= '0;
      cnt_q   <= '0;
      sym_q   <= '0;
      run_q   <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef LTL_SYMBOL_DEDUP_EN
      last_q     <= '0;
      last_vld_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      seq_q   <= seq_d;
      cnt_q   <= cnt_d;
      sym_q   <= sym_d;
      run_q   <= run_d;
      ovf_q   <= ovf_d;
`ifdef LTL_SYMBOL_DEDUP_EN
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
`endif
    end
  end

  assign symbols   = sym_q;
  assign run       = run_q;
  assign overflow  = ovf_q;
  assign sym_count = cnt_q;

endmodule

// File: tb/tb_ltl_symbol_streamer.sv
// Scoreboard bench for ltl_symbol_streamer; the dedup case runs when LTL_SYMBOL_DEDUP_EN is defined.
module tb_ltl_symbol_streamer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        prop_valid = 1'b0;
  logic        prop_ready;
  logic [2:0]  props = 3'b000;
  logic        flush = 1'b0;
  logic        mon_stall = 1'b0;
  logic [7:0]  symbols;
  logic        run;
  logic        mon_reset;
  logic        overflow;
  logic [15:0] sym_count;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  sb[$];
  logic [3:0]  exp_seq = 4'h0;
  logic [7:0]  mon_exp;

  ltl_symbol_streamer #(.DEPTH(8), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .prop_valid (prop_valid),
    .prop_ready (prop_ready),
    .props      (props),
    .flush      (flush),
    .mon_stall  (mon_stall),
    .symbols    (symbols),
    .run        (run),
    .mon_reset  (mon_reset),
    .overflow   (overflow),
    .sym_count  (sym_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one vector for one cycle; when accepted and tracked, queue its expected symbol.
  task automatic offer(input logic [2:0] p, input logic exp_acc, input logic track);
    prop_valid = 1'b1;
    props      = p;
    check("prop_ready", {31'b0, prop_ready}, {31'b0, exp_acc});
    if (exp_acc && track) begin
      sb.push_back({1'b0, p, exp_seq});
      exp_seq = exp_seq + 4'h1;
    end
    step();
    prop_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) step();
    step();
    check("drain_empty", sb.size(), 0);
    check("run_idle", {31'b0, run}, 0);
  endtask

  task automatic restart();
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    step();
    sb.delete();
    exp_seq = 4'h0;
  endtask

  // Monitor: every run pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && run) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_symbol: got %h expected none", symbols);
      end else begin
        mon_exp = sb.pop_front();
        if (symbols !== mon_exp) begin
          errors++;
          $display("FAIL symbol: got %h expected %h", symbols, mon_exp);
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_mon_reset", {31'b0, mon_reset}, 1);
    check("rst_prop_ready", {31'b0, prop_ready}, 0);
    check("rst_run", {31'b0, run}, 0);
    check("rst_symbols", {24'b0, symbols}, 0);
    check("rst_overflow", {31'b0, overflow}, 0);
    check("rst_sym_count", {16'b0, sym_count}, 0);

    // Restart window after reset release.
    reset = 1'b0;
    check("rs1_mon_reset", {31'b0, mon_reset}, 1);
    check("rs1_prop_ready", {31'b0, prop_ready}, 0);
    step();
    check("rs2_mon_reset", {31'b0, mon_reset}, 1);
    check("rs2_prop_ready", {31'b0, prop_ready}, 0);
    step();
    check("rs3_mon_reset", {31'b0, mon_reset}, 0);
    check("rs3_prop_ready", {31'b0, prop_ready}, 1);

    // Back-to-back pair: 0x50 then 0x21.
    offer(3'b101, 1'b1, 1'b0);
    sb.push_back(8'h50);
    offer(3'b010, 1'b1, 1'b0);
    sb.push_back(8'h21);
    exp_seq = 4'h2;
    drain();
    check("pair_sym_count", {16'b0, sym_count}, 2);
    check("pair_hold_symbols", {24'b0, symbols}, 32'h21);

    // Fill under stall, overflow on the 9th offer, then release in order with seq 0..7.
    restart();
    mon_stall = 1'b1;
    for (int i = 0; i < 8; i++) offer(3'(i), 1'b1, 1'b1);
    check("full_no_overflow", {31'b0, overflow}, 0);
    offer(3'b111, 1'b0, 1'b1);
    check("overflow_set", {31'b0, overflow}, 1);
    check("full_prop_ready", {31'b0, prop_ready}, 0);
    check("stall_no_emit", {16'b0, sym_count}, 0);
    check("stall_no_run", {31'b0, run}, 0);
    mon_stall = 1'b0;
    drain();
    check("stall_sym_count", {16'b0, sym_count}, 8);
    check("overflow_sticky", {31'b0, overflow}, 1);

    // Flush with 3 queued entries; the same cycle would otherwise pop.
    mon_stall = 1'b1;
    for (int i = 0; i < 3; i++) offer(3'(i + 5), 1'b1, 1'b1);
    sb.delete();
    mon_stall = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_run", {31'b0, run}, 0);
    check("flush_mon_reset1", {31'b0, mon_reset}, 1);
    check("flush_sym_count", {16'b0, sym_count}, 0);
    check("flush_overflow", {31'b0, overflow}, 0);
    check("flush_prop_ready", {31'b0, prop_ready}, 0);
    step();
    check("flush_mon_reset2", {31'b0, mon_reset}, 1);
    check("flush_run2", {31'b0, run}, 0);
    step();
    check("flush_mon_reset3", {31'b0, mon_reset}, 0);
    check("flush_prop_ready3", {31'b0, prop_ready}, 1);
    exp_seq = 4'h0;

    // 17 symbols back to back: first has seq 0, 17th wraps to seq 0 (props 1 -> 0x10).
    for (int i = 0; i < 17; i++) offer(3'(i + 1), 1'b1, 1'b1);
    drain();
    check("wrap_sym_count", {16'b0, sym_count}, 17);
    check("wrap_last_symbol", {24'b0, symbols}, 32'h10);

`ifdef LTL_SYMBOL_DEDUP_EN
    restart();
    sb.push_back(8'h30);
    sb.push_back(8'h41);
    offer(3'b011, 1'b1, 1'b0);
    offer(3'b011, 1'b1, 1'b0);
    offer(3'b011, 1'b1, 1'b0);
    offer(3'b100, 1'b1, 1'b0);
    drain();
    check("dedup_sym_count", {16'b0, sym_count}, 2);
    check("dedup_last_symbol", {24'b0, symbols}, 32'h41);
`endif

    // Async reset mid-stream drops queued data and returns outputs to reset values.
    mon_stall = 1'b1;
    offer(3'b110, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("amid_mon_reset", {31'b0, mon_reset}, 1);
    check("amid_sym_count", {16'b0, sym_count}, 0);
    check("amid_symbols", {24'b0, symbols}, 0);
    mon_stall = 1'b0;
    step();
    reset = 1'b0;
    step();
    step();
    step();
    check("amid_no_run", {31'b0, run}, 0);
    check("amid_count_after", {16'b0, sym_count}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ltl_symbol_streamer.md
# ltl_symbol_streamer

Producer side of the LTL runtime monitors. It accepts per-event atomic-proposition vectors from the core-trace tap over a valid/ready handshake and buffers them in a small FIFO. Each vector is encoded into the 8-bit symbol format that the monitor automata consume. The block also drives the automata `symbols` / `run` / `reset` inputs, including the reset pulse that produces the automata's start-of-data condition.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `CNT_W`, 16: width of the emitted-symbol counter.

Ports:
- `clk`  in  1  clock; all state on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `prop_valid`  in  1  a proposition vector is offered.
- `prop_ready`  out  1  the block accepts the vector this cycle.
- `props`  in  3  atomic propositions p[2:0] for one event.
- `flush`  in  1  synchronous; discard the queue and restart the monitors.
- `mon_stall`  in  1  the monitor side pauses; no symbol is emitted.
- `symbols`  out  8  symbol to the automata.
- `run`  out  1  `symbols` is a new, valid symbol this cycle.
- `mon_reset`  out  1  reset to the automata.
- `overflow`  out  1  sticky; a vector was offered while the FIFO was full.
- `sym_count`  out  CNT_W  number of symbols emitted since the last restart.

## Operation
Symbol encoding is `{1'b0, p[2:0], seq[3:0]}`:
- `seq` is a 4-bit counter that increments on every emitted symbol and wraps 15→0.
- The automata match on 16-aligned ranges, so they ignore `seq`; it exists for trace debug only.

FSM:
- States: RESTART, STREAM.
- Reset enters RESTART.
- RESTART lasts exactly 2 cycles. During it, `mon_reset`=1, `prop_ready`=0 and `run`=0. It then goes to STREAM.
- STREAM:
  - `mon_reset`=0 and `prop_ready`=~full.
  - Push when `prop_valid && prop_ready`.
  - Pop when ~empty && ~`mon_stall`.
  - A pop registers the encoded symbol into `symbols`, sets `run`=1 for one cycle, increments `seq`, and increments `sym_count`. `sym_count` saturates at all-ones.
- `flush` in any state:
  - Empties the FIFO and clears `seq`, `sym_count` and `overflow`.
  - Forces `run`=0 and enters RESTART; the 2-cycle count restarts.
  - A vector offered in the same cycle is not accepted.

Other rules:
- `overflow` sets when `prop_valid && !prop_ready` in STREAM. It does not set during RESTART. It stays set until `flush` or `reset`.
- When no pop occurs, `symbols` holds its last value and `run`=0.

## Timing
Reset values:
- `symbols`=8'h00, `run`=0, `mon_reset`=1, `prop_ready`=0, `overflow`=0, `sym_count`=0, FIFO empty, `seq`=0.

Latency:
- A vector accepted at edge t into an empty FIFO with `mon_stall`=0 appears on `symbols`, with `run`=1, in the cycle after edge t+1.
- Sustained throughput is 1 symbol per cycle.

Full and empty:
- `prop_ready` depends only on full. A full FIFO refuses a push even if a pop happens in the same cycle.
- A simultaneous push and pop at a non-full, non-empty level keeps the occupancy unchanged.

Stall:
- `mon_stall` is sampled in the same cycle as the pop decision.
- Raising it stops `run` from the next cycle; there is no skid.

Reset mid-stream:
- Outputs go to their reset values asynchronously and queued data is lost.

## Configuration
Macro: `LTL_SYMBOL_DEDUP_EN`.
- Defined: a pushed vector equal to the last enqueued vector is handshaken (`prop_ready` as normal) but not enqueued. The compare register is cleared by restart, so the first vector after a restart is always enqueued.
- Undefined: every accepted vector is enqueued.

## Structure
- Package `ltl_mon_pkg`:
  - `SYM_W`=8, `PROP_W`=3, `SEQ_W`=4.
  - The FSM state enum.
  - Function `encode_symbol(props, seq)`.
- Sub-module `ltl_sym_fifo`:
  - Synchronous FIFO with DEPTH entries of width PROP_W.
  - Async reset, sync clear.
  - Outputs `full` and `empty`; pointers carry one extra wrap bit.

## Test plan
- Reset release → `mon_reset`=1 for 2 cycles, then 0. `prop_ready` rises in the third cycle.
- Push `props`=3'b101 then 3'b010 back-to-back, no stall → `run`=1 on two consecutive cycles with `symbols`=8'h50 then 8'h21. `sym_count`=2.
- Hold `mon_stall`=1 and push 9 vectors with DEPTH=8 → 8 are accepted and `prop_ready`=0 at full. `overflow`=1 after the 9th offer. Releasing the stall emits 8 symbols in order with `seq` 0..7.
- Emit 17 symbols → the 17th symbol has `seq`=0 (wrap).
- `flush` while the FIFO holds 3 entries → `run`=0, `mon_reset`=1 for 2 cycles. `sym_count` and `overflow` are cleared and the next symbol has `seq`=0.
- With `LTL_SYMBOL_DEDUP_EN`, push 3'b011 three times then 3'b100 → only 8'h30 and 8'h41 are emitted.
